div_rem_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/div_iter_step.sv | 24 ++
 rtl/div_rem_seq.sv | 146 ++++++++++++++
 tb/tb_div_rem_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the M-extension divide/remainder sequencer.
// Operation codes match funct3[1:0] of DIV/DIVU/REM/REMU.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } state_t;

  function automatic logic is_signed_op(div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor in W+1 bits and keep the difference when it does not underflow.
module div_iter_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] rem_sh;
  logic       ge;

  always_comb begin
    rem_sh = {rem_i, quo_i[W-1]};
    ge     = (rem_sh >= {1'b0, divisor_i});
    // A successful trial always leaves a remainder below the divisor, so it fits in W bits.
    rem_o  = ge ? W'(rem_sh - {1'b0, divisor_i}) : rem_sh[W-1:0];
    quo_o  = {quo_i[W-2:0], ge};
  end

endmodule

// File: rtl/div_rem_seq.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Works on magnitudes, fixes signs in FIXUP, and short-circuits b==0 and MIN/-1.
module div_rem_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  div_op_t               op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output state_t                dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN_VAL = {1'b1, {(W-1){1'b0}}};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  div_op_t       op_q, op_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [W-1:0]  result_q, result_d;
  logic          result_en;

  logic [W-1:0]  step_rem, step_quo;
  logic          a_neg, b_neg, div_zero, overflow, special;
  logic [W-1:0]  a_mag, b_mag, special_res, fix_quo, fix_rem, fix_res;

  div_iter_step #(.W(W)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Decode of the incoming operation, used only on the accept edge.
  always_comb begin
    a_neg    = is_signed_op(op) && op_a[W-1];
    b_neg    = is_signed_op(op) && op_b[W-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = (op_b == '0);
    overflow = is_signed_op(op) && (op_a == MIN_VAL) && (op_b == '1);
    special  = div_zero || overflow;
    if (div_zero) special_res = is_rem_op(op) ? op_a : '1;
    else          special_res = is_rem_op(op) ? '0   : op_a;
  end

  always_comb begin
    fix_quo = (is_signed_op(op_q) && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    fix_rem = (is_signed_op(op_q) && sign_a_q) ? -rem_q : rem_q;
    fix_res = is_rem_op(op_q) ? fix_rem : fix_quo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = special ? DONE : RUN;
      RUN:     if (flush) state_d = IDLE;
               else if (cnt_q == LAST) state_d = FIXUP;
      FIXUP:   state_d = flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    result    = result_q;
    dbg_state = state_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    result_en = 1'b0;
    if (state_q == IDLE && start) begin
      cnt_d    = '0;
      op_d     = op;
      sign_a_d = op_a[W-1];
      sign_b_d = op_b[W-1];
      rem_d    = '0;
      quo_d    = a_mag;
      dvs_d    = b_mag;
      if (special) begin
        result_d  = special_res;
        result_en = 1'b1;
      end
    end else if (state_q == RUN && !flush) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end else if (state_q == FIXUP && !flush) begin
      result_d  = fix_res;
      result_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= OP_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          result_q <= '0;
    else if (result_en) result_q <= result_d;
  end

endmodule

// File: tb/tb_div_rem_seq.sv
// Directed and random checks of div_rem_seq against a plain-arithmetic
// RISC-V divide/remainder model, including handshake timing and aborts.
module tb_div_rem_seq;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;
  localparam logic [W-1:0] MAX_V = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  div_op_t       op;
  logic [W-1:0]  op_a, op_b, result;
  logic          busy, done;
  state_t        dbg_state;

  int tests_run = 0;
  int failed    = 0;

  div_rem_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(div_op_t o, logic [W-1:0] a, logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      OP_DIVU: return (b == 0) ? '1 : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == MIN_V && b == '1) return a;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == MIN_V && b == '1) return '0;
        return sa % sb;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return MIN_V;
      4: return MAX_V;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from IDLE and follow it to the cycle after done.
  task automatic run_op(input div_op_t o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] exp;
    int           exp_lat, lat;
    logic         busy_ok;
    exp     = ref_model(o, a, b);
    exp_lat = ((b == 0) || ((o == OP_DIV || o == OP_REM) && a == MIN_V && b == '1)) ? 1 : W + 2;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " busy"}, W'(busy_ok && busy), W'(1));
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " idle"}, W'({busy, done}), W'(0));
    check({tag, " held"}, result, exp);
  endtask

  initial begin
    int lat, n_done;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = OP_DIV; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset result", result, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post reset state", W'({busy, done}), W'(0));

    run_op(OP_DIVU, 32'd100, 32'd7, "divu 100/7");
    run_op(OP_REMU, 32'd100, 32'd7, "remu 100/7");
    run_op(OP_DIV, -32'sd7, 32'd2, "div -7/2");
    run_op(OP_REM, -32'sd7, 32'd2, "rem -7/2");
    run_op(OP_REM, 32'd7, -32'sd2, "rem 7/-2");
    run_op(OP_DIVU, 32'h1234, 32'd0, "divu by zero");
    run_op(OP_REM, -32'sd5, 32'd0, "rem by zero");
    run_op(OP_DIV, MIN_V, '1, "div overflow");
    run_op(OP_REM, MIN_V, '1, "rem overflow");

    // start pulsed during RUN and during DONE must be ignored
    @(negedge clk);
    op = OP_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    op = OP_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    check("ign run latency", W'(lat), W'(W + 2));
    check("ign run result", result, 32'd14);
    op = OP_DIVU; op_a = 32'd50; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign done busy", W'(busy), W'(0));
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    check("ign no extra done", W'(n_done), W'(0));
    check("ign result kept", result, 32'd14);
    run_op(OP_DIVU, 32'd50, 32'd5, "after ignore");

    // flush at N+10
    @(negedge clk);
    op = OP_DIVU; op_a = 32'hFFFF; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", W'(busy), W'(0));
    check("flush state", W'(dbg_state), W'(IDLE));
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    check("flush no done", W'(n_done), W'(0));
    check("flush result kept", result, 32'd10);

    // reset at N+20
    @(negedge clk);
    op = OP_DIV; op_a = -32'sd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy", W'(busy), W'(0));
    check("midreset done", W'(done), W'(0));
    check("midreset result", result, '0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    check("midreset no done", W'(n_done), W'(0));
    run_op(OP_REM, 32'd17, 32'd5, "after reset");

    for (int i = 0; i < 1200; i++) begin
      run_op(div_op_t'($urandom_range(0, 3)), rand_val(), rand_val(), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
